zint_pulser: RTL and testbench



---
 rtl/zint_pulser.sv | 161 ++++++++++++++++
 tb/tb_zint_pulser.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zint_pulser.sv
// zint_pulser: Z80 /INT request generator for the W5300 and SL811 sources.
// Raw interrupt lines are synchronised, edge-detected into sticky pending
// flags (cleared by port writes), and a fixed-width /INT pulse is issued,
// followed by a holdoff, while any enabled source stays pending.
// Optional build macro: ZINT_LEVEL_SRC_EN -- pending flags follow the synced
// source level (set every clk the source is active) instead of its rising edge.
module zint_pulser #(
  parameter int INT_LEN     = 32,
  parameter int HOLD_LEN    = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       w5300_int_n,
  input  logic       sl811_intrq,
  input  logic       ena_w5300_int,
  input  logic       ena_sl811_int,
  input  logic       ena_zxbus_int,
  input  logic       clr_stb,
  input  logic [1:0] clr_mask,
  output logic [1:0] pending,
  output logic       internal_int,
  output logic       zint_req
);

  localparam int MAX_LEN = (INT_LEN > HOLD_LEN) ? INT_LEN : HOLD_LEN;
  localparam int CNT_W   = ($clog2(MAX_LEN) > 0) ? $clog2(MAX_LEN) : 1;
  localparam logic [CNT_W-1:0] INT_LAST  = CNT_W'(INT_LEN - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  // Both sources normalised to active-high: bit0 = W5300, bit1 = SL811
  logic [1:0] src;
  logic [1:0] synced;
  logic [1:0] set;

  assign src = {sl811_intrq, ~w5300_int_n};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic [SYNC_STAGES-1:0] sync_reg;

      // Multi-stage synchroniser for the asynchronous source pin
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], src[gi]};
        end
      end

      assign synced[gi] = sync_reg[SYNC_STAGES-1];

`ifdef ZINT_LEVEL_SRC_EN
      // Level mode: an active source keeps re-asserting its pending flag
      assign set[gi] = synced[gi];
`else
      logic prev_reg;

      // Previous synced value, used to detect the rising edge
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          prev_reg <= 1'b0;
        end else begin
          prev_reg <= synced[gi];
        end
      end

      assign set[gi] = synced[gi] & ~prev_reg;
`endif
    end
  endgenerate

  logic [1:0] pending_reg;
  logic [1:0] pending_next;

  // Clear selected flags on a strobe; a simultaneous set takes priority
  always_comb begin
    pending_next = (pending_reg & ~({2{clr_stb}} & clr_mask)) | set;
  end

  // Sticky pending flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg <= 2'b00;
    end else begin
      pending_reg <= pending_next;
    end
  end

  assign pending      = pending_reg;
  assign internal_int = |(pending_reg & {ena_sl811_int, ena_w5300_int});

  logic int_req;
  assign int_req = internal_int & ena_zxbus_int;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             zint_req_reg;
  logic             zint_req_next;

  // Pulse / holdoff sequencing; holdoff ignores requests until it expires
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    zint_req_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (int_req) begin
          state_next = PULSE;
          cnt_next   = INT_LAST;
        end
      end
      PULSE: begin
        // Losing the request truncates the pulse but still enforces holdoff
        if (!int_req || (cnt_reg == '0)) begin
          state_next = HOLDOFF;
          cnt_next   = HOLD_LAST;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      HOLDOFF: begin
        if (cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    zint_req_next = (state_next == PULSE);
  end

  // FSM state, counter and the registered (glitch-free) /INT request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      zint_req_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      zint_req_reg <= zint_req_next;
    end
  end

  assign zint_req = zint_req_reg;

endmodule

// File: tb/tb_zint_pulser.sv
// tb_zint_pulser: self-checking bench for zint_pulser with default parameters.
// Expected pulse start cycles / widths are queued when stimulus is applied and
// popped when the DUT raises zint_req. Honours ZINT_LEVEL_SRC_EN if defined.
module tb_zint_pulser;

  localparam int INT_LEN     = 32;
  localparam int HOLD_LEN    = 1024;
  localparam int SYNC_STAGES = 2;
  localparam int PERIOD_CLKS = INT_LEN + HOLD_LEN + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       w5300_int_n = 1'b1;
  logic       sl811_intrq = 1'b0;
  logic       ena_w5300_int = 1'b0;
  logic       ena_sl811_int = 1'b0;
  logic       ena_zxbus_int = 1'b0;
  logic       clr_stb = 1'b0;
  logic [1:0] clr_mask = 2'b00;
  logic [1:0] pending;
  logic       internal_int;
  logic       zint_req;

  int cyc = 0;
  int n_checks = 0;
  int n_fails = 0;

  typedef struct {
    int start;
    int width;
  } pulse_t;
  pulse_t exp_q[$];

  zint_pulser #(
    .INT_LEN(INT_LEN),
    .HOLD_LEN(HOLD_LEN),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .w5300_int_n(w5300_int_n),
    .sl811_intrq(sl811_intrq),
    .ena_w5300_int(ena_w5300_int),
    .ena_sl811_int(ena_sl811_int),
    .ena_zxbus_int(ena_zxbus_int),
    .clr_stb(clr_stb),
    .clr_mask(clr_mask),
    .pending(pending),
    .internal_int(internal_int),
    .zint_req(zint_req)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Wait (bounded) for zint_req to be seen high at a falling edge
  task automatic wait_rise(input int limit, output int at, output bit timeout);
    timeout = 1'b1;
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (zint_req === 1'b1) begin
        at = cyc;
        timeout = 1'b0;
        break;
      end
    end
  endtask

  // Measure start cycle and width of the next pulse
  task automatic measure_pulse(input int limit, output int at, output int width, output bit timeout);
    width = 0;
    wait_rise(limit, at, timeout);
    if (!timeout) begin
      width = 1;
      for (int i = 0; i < 4 * INT_LEN; i++) begin
        @(negedge clk);
        if (zint_req !== 1'b1) break;
        width++;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({pending, internal_int, zint_req} !== 4'b0000) begin
      n_fails++;
      $display("FAIL reset_hold: got %b expected 0000", {pending, internal_int, zint_req});
    end
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ({pending, internal_int, zint_req} !== 4'b0000) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fails++;
      $display("FAIL reset_idle: got %0d nonzero cycles expected 0", bad);
    end
    $display("reset: released, idle window checked");
  endtask

  task automatic test_w5300_pulse();
    int c0, at, width, highs;
    bit to;
    pulse_t e;
    @(negedge clk);
    ena_w5300_int = 1'b1;
    ena_zxbus_int = 1'b1;
    w5300_int_n = 1'b0;
    c0 = cyc;
    exp_q.push_back('{c0 + SYNC_STAGES + 2, INT_LEN});
    exp_q.push_back('{c0 + SYNC_STAGES + 2 + PERIOD_CLKS, INT_LEN});
    repeat (SYNC_STAGES) @(negedge clk);
    n_checks++;
    if (pending[0] !== 1'b0) begin
      n_fails++;
      $display("FAIL w5300_pend_early: got %b expected 0", pending[0]);
    end
    @(negedge clk);
    n_checks++;
    if (pending !== 2'b01) begin
      n_fails++;
      $display("FAIL w5300_pend_set: got %b expected 01", pending);
    end
    for (int k = 0; k < 2; k++) begin
      measure_pulse(2 * PERIOD_CLKS, at, width, to);
      e = exp_q.pop_front();
      n_checks++;
      if (to || at != e.start) begin
        n_fails++;
        $display("FAIL w5300_start%0d: got %0d expected %0d", k, at, e.start);
      end
      n_checks++;
      if (width != e.width) begin
        n_fails++;
        $display("FAIL w5300_width%0d: got %0d expected %0d", k, width, e.width);
      end
      $display("w5300 pulse %0d: start %0d width %0d", k, at, width);
    end
    // Now in holdoff: clear the flag, no further pulse expected
    repeat (100) @(negedge clk);
    clr_stb = 1'b1;
    clr_mask = 2'b01;
    @(negedge clk);
    clr_stb = 1'b0;
    w5300_int_n = 1'b1;
    n_checks++;
    if ({pending, internal_int} !== 3'b000) begin
      n_fails++;
      $display("FAIL w5300_clear: got %b expected 000", {pending, internal_int});
    end
    highs = 0;
    for (int i = 0; i < PERIOD_CLKS + 200; i++) begin
      @(negedge clk);
      if (zint_req !== 1'b0) highs++;
    end
    n_checks++;
    if (highs != 0) begin
      n_fails++;
      $display("FAIL w5300_no_repeat: got %0d high cycles expected 0", highs);
    end
    $display("w5300 cleared in holdoff: no repeat");
  endtask

  task automatic test_sl811_masked();
    int at, width, highs;
    bit to;
    pulse_t e;
    @(negedge clk);
    ena_sl811_int = 1'b0;
    ena_zxbus_int = 1'b1;
    sl811_intrq = 1'b1;
    repeat (SYNC_STAGES + 1) @(negedge clk);
    n_checks++;
    if ({pending, internal_int} !== 3'b100) begin
      n_fails++;
      $display("FAIL sl811_masked_pend: got %b expected 100", {pending, internal_int});
    end
    highs = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (zint_req !== 1'b0) highs++;
    end
    n_checks++;
    if (highs != 0) begin
      n_fails++;
      $display("FAIL sl811_masked_quiet: got %0d high cycles expected 0", highs);
    end
    ena_sl811_int = 1'b1;
    exp_q.push_back('{cyc + 1, INT_LEN});
    #1;
    n_checks++;
    if (internal_int !== 1'b1) begin
      n_fails++;
      $display("FAIL sl811_internal: got %b expected 1", internal_int);
    end
    measure_pulse(10, at, width, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to || at != e.start || width != e.width) begin
      n_fails++;
      $display("FAIL sl811_pulse: got start %0d width %0d expected start %0d width %0d",
               at, width, e.start, e.width);
    end
    $display("sl811 unmasked: pulse start %0d width %0d", at, width);
    clr_stb = 1'b1;
    clr_mask = 2'b10;
    sl811_intrq = 1'b0;
    @(negedge clk);
    clr_stb = 1'b0;
    highs = 0;
    for (int i = 0; i < HOLD_LEN + 50; i++) begin
      @(negedge clk);
      if (zint_req !== 1'b0) highs++;
    end
    n_checks++;
    if (highs != 0 || pending !== 2'b00) begin
      n_fails++;
      $display("FAIL sl811_cleared: got %0d highs pending %b expected 0 highs pending 00", highs, pending);
    end
  endtask

  task automatic test_set_wins();
    logic [1:0] exp_after;
    @(negedge clk);
    ena_zxbus_int = 1'b0;
    sl811_intrq = 1'b1;
    repeat (SYNC_STAGES + 1) @(negedge clk);
    n_checks++;
    if (pending !== 2'b10) begin
      n_fails++;
      $display("FAIL setwins_pre: got %b expected 10", pending);
    end
    w5300_int_n = 1'b0;
    repeat (SYNC_STAGES) @(negedge clk);
    // Synced W5300 rising edge is present during this cycle
    clr_stb = 1'b1;
    clr_mask = 2'b11;
    @(negedge clk);
    clr_stb = 1'b0;
`ifdef ZINT_LEVEL_SRC_EN
    exp_after = 2'b11;
`else
    exp_after = 2'b01;
`endif
    n_checks++;
    if (pending !== exp_after) begin
      n_fails++;
      $display("FAIL setwins_same_clk: got %b expected %b", pending, exp_after);
    end
    clr_stb = 1'b1;
    clr_mask = 2'b01;
    @(negedge clk);
    clr_stb = 1'b0;
`ifdef ZINT_LEVEL_SRC_EN
    exp_after = 2'b11;
`else
    exp_after = 2'b00;
`endif
    n_checks++;
    if (pending !== exp_after) begin
      n_fails++;
      $display("FAIL setwins_later_clear: got %b expected %b", pending, exp_after);
    end
    $display("set-wins: pending %b", pending);
    w5300_int_n = 1'b1;
    sl811_intrq = 1'b0;
    repeat (SYNC_STAGES + 1) @(negedge clk);
    clr_stb = 1'b1;
    clr_mask = 2'b11;
    @(negedge clk);
    clr_stb = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_drop_and_reset();
    int c0, at, s;
    bit to;
    pulse_t e;
    @(negedge clk);
    ena_w5300_int = 1'b1;
    ena_sl811_int = 1'b0;
    ena_zxbus_int = 1'b1;
    w5300_int_n = 1'b0;
    c0 = cyc;
    exp_q.push_back('{c0 + SYNC_STAGES + 2, INT_LEN});
    wait_rise(20, at, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to || at != e.start) begin
      n_fails++;
      $display("FAIL drop_start: got %0d expected %0d", at, e.start);
    end
    s = at;
    repeat (9) @(negedge clk);
    n_checks++;
    if (zint_req !== 1'b1) begin
      n_fails++;
      $display("FAIL drop_mid_pulse: got %b expected 1", zint_req);
    end
    ena_zxbus_int = 1'b0;
    @(negedge clk);
    n_checks++;
    if (zint_req !== 1'b0) begin
      n_fails++;
      $display("FAIL drop_truncate: got %b expected 0", zint_req);
    end
    // Re-enable at once: holdoff must still run its full length
    ena_zxbus_int = 1'b1;
    exp_q.push_back('{s + 10 + HOLD_LEN + 1, INT_LEN});
    wait_rise(HOLD_LEN + 50, at, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to || at != e.start) begin
      n_fails++;
      $display("FAIL drop_holdoff: got %0d expected %0d", at, e.start);
    end
    $display("truncated pulse at %0d, next pulse at %0d", s, at);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    w5300_int_n = 1'b1;
    #1;
    n_checks++;
    if ({pending, zint_req} !== 3'b000) begin
      n_fails++;
      $display("FAIL async_reset: got %b expected 000", {pending, zint_req});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({pending, internal_int, zint_req} !== 4'b0000) begin
      n_fails++;
      $display("FAIL post_reset: got %b expected 0000", {pending, internal_int, zint_req});
    end
    $display("async reset mid-pulse: outputs cleared");
  endtask

  task automatic test_level_hold();
    logic exp_bit;
    @(negedge clk);
    ena_zxbus_int = 1'b0;
    sl811_intrq = 1'b1;
    repeat (SYNC_STAGES + 1) @(negedge clk);
    n_checks++;
    if (pending[1] !== 1'b1) begin
      n_fails++;
      $display("FAIL hold_set: got %b expected 1", pending[1]);
    end
    clr_stb = 1'b1;
    clr_mask = 2'b10;
    @(negedge clk);
    clr_stb = 1'b0;
`ifdef ZINT_LEVEL_SRC_EN
    exp_bit = 1'b1;
`else
    exp_bit = 1'b0;
`endif
    n_checks++;
    if (pending[1] !== exp_bit) begin
      n_fails++;
      $display("FAIL hold_clear: got %b expected %b", pending[1], exp_bit);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (pending[1] !== exp_bit) begin
      n_fails++;
      $display("FAIL hold_stable: got %b expected %b", pending[1], exp_bit);
    end
    sl811_intrq = 1'b0;
    repeat (SYNC_STAGES + 1) @(negedge clk);
    clr_stb = 1'b1;
    clr_mask = 2'b10;
    @(negedge clk);
    clr_stb = 1'b0;
    n_checks++;
    if (pending[1] !== 1'b0) begin
      n_fails++;
      $display("FAIL hold_release: got %b expected 0", pending[1]);
    end
    $display("held level: pending[1] after clear %b", exp_bit);
  endtask

  initial begin
    test_reset();
    test_w5300_pulse();
    test_sl811_masked();
    test_set_wins();
    test_drop_and_reset();
    test_level_hold();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
